// File: rtl/seq_pkg.sv
// Shared constants for the multi-cycle sequencer: state codes, control-word
// width and the bit position of every control-word field.
package seq_pkg;

   localparam int CW_W = 38;

   typedef logic [2:0] state_t;

   localparam state_t ST_RST    = 3'd0;
   localparam state_t ST_FETCH  = 3'd1;
   localparam state_t ST_DECODE = 3'd2;
   localparam state_t ST_EXEC   = 3'd3;
   localparam state_t ST_MEM    = 3'd4;
   localparam state_t ST_WB     = 3'd5;
   localparam state_t ST_HALT   = 3'd6;
   localparam state_t ST_FAULT  = 3'd7;

   localparam int PCSEL_BIT  = 0;
   localparam int SELB_BIT   = 1;
   localparam int SL_BIT     = 2;
   localparam int PS_LSB     = 3;
   localparam int PS_MSB     = 4;
   localparam int EN_PC_BIT  = 5;
   localparam int EN_B_BIT   = 6;
   localparam int EN_ALU_BIT = 7;
   localparam int EN_EM_BIT  = 8;
   localparam int WM_BIT     = 9;
   localparam int WR_BIT     = 10;
   localparam int FS_LSB     = 11;
   localparam int FS_MSB     = 15;
   localparam int IMM_LSB    = 16;
   localparam int IMM_MSB    = 27;
   localparam int SA_LSB     = 28;
   localparam int SA_MSB     = 32;
   localparam int DA_LSB     = 33;
   localparam int DA_MSB     = 37;

   localparam logic [1:0] PS_HOLD = 2'b00;

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter shared by the instruction fetch and data memory phases;
// flags the last cycle a memory is allowed to stall before the sequencer faults.
module seq_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] wait_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (clear) begin
         wait_cnt <= '0;
      end else if (enable) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign expired = (wait_cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer: holds ir, registers the
// decoded control word and releases each strobe only in its own phase.
module cpu_sequencer
   import seq_pkg::*;
#(
   parameter int CW_W        = seq_pkg::CW_W,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic            imem_req,
   output logic [31:0]     ir,
   input  logic [CW_W-1:0] cw_in,
   output logic [CW_W-1:0] cw_out,
   input  logic            dmem_ready,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            halt_req,
   output logic            halted,
   output logic            fault,
   output logic [31:0]     retired
);

   state_t          state;
   state_t          state_n;
   logic [31:0]     ir_q;
   logic [CW_W-1:0] cw_reg;
   logic [31:0]     retired_q;
   logic            ir_load;
   logic            cw_load;
   logic            retire;
   logic            wait_en;
   logic            wait_clr;
   logic            wait_expired;

   seq_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (wait_clr),
      .enable (wait_en),
      .expired(wait_expired)
   );

   // A ready arriving on the final allowed wait cycle takes priority over the timeout.
   always_comb begin
      state_n  = state;
      ir_load  = 1'b0;
      cw_load  = 1'b0;
      retire   = 1'b0;
      wait_en  = 1'b0;
      wait_clr = 1'b1;
      case (state)
         ST_RST:    state_n = ST_FETCH;
         ST_FETCH: begin
            if (imem_ready) begin
               ir_load = 1'b1;
               state_n = ST_DECODE;
            end else if (wait_expired) begin
               state_n = ST_FAULT;
            end else begin
               wait_en  = 1'b1;
               wait_clr = 1'b0;
            end
         end
         ST_DECODE: begin
            cw_load = 1'b1;
            state_n = ST_EXEC;
         end
         ST_EXEC:   state_n = cw_reg[EN_EM_BIT] ? ST_MEM : ST_WB;
         ST_MEM: begin
            if (dmem_ready) begin
               state_n = ST_WB;
            end else if (wait_expired) begin
               state_n = ST_FAULT;
            end else begin
               wait_en  = 1'b1;
               wait_clr = 1'b0;
            end
         end
         ST_WB: begin
            retire  = 1'b1;
            state_n = halt_req ? ST_HALT : ST_FETCH;
         end
         ST_HALT:   state_n = halt_req ? ST_HALT : ST_FETCH;
         ST_FAULT:  state_n = ST_FAULT;
         default:   state_n = ST_RST;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_RST;
         ir_q      <= '0;
         cw_reg    <= '0;
         retired_q <= '0;
      end else begin
         state <= state_n;
         if (ir_load) ir_q <= imem_rdata;
         if (cw_load) cw_reg <= cw_in;
         if (retire) retired_q <= retired_q + 32'd1;
      end
   end

   // Strobes depend only on state and cw_reg, so reset silences them at once.
   always_comb begin
      cw_out = '0;
      if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
         cw_out[DA_MSB:DA_LSB]   = cw_reg[DA_MSB:DA_LSB];
         cw_out[SA_MSB:SA_LSB]   = cw_reg[SA_MSB:SA_LSB];
         cw_out[IMM_MSB:IMM_LSB] = cw_reg[IMM_MSB:IMM_LSB];
         cw_out[FS_MSB:FS_LSB]   = cw_reg[FS_MSB:FS_LSB];
         cw_out[EN_ALU_BIT]      = cw_reg[EN_ALU_BIT];
         cw_out[EN_B_BIT]        = cw_reg[EN_B_BIT];
         cw_out[SL_BIT]          = cw_reg[SL_BIT];
         cw_out[SELB_BIT]        = cw_reg[SELB_BIT];
         cw_out[PCSEL_BIT]       = cw_reg[PCSEL_BIT];
      end
      if (state == ST_MEM) begin
         cw_out[EN_EM_BIT] = cw_reg[EN_EM_BIT];
         cw_out[WM_BIT]    = cw_reg[WM_BIT];
      end
      if (state == ST_WB) begin
         cw_out[WR_BIT]        = cw_reg[WR_BIT];
         cw_out[EN_PC_BIT]     = cw_reg[EN_PC_BIT];
         cw_out[PS_MSB:PS_LSB] = cw_reg[PS_MSB:PS_LSB];
      end else begin
         cw_out[PS_MSB:PS_LSB] = PS_HOLD;
      end
   end

   assign imem_req = (state == ST_FETCH);
   assign dmem_req = (state == ST_MEM);
   assign dmem_we  = (state == ST_MEM) && cw_reg[WM_BIT];
   assign halted   = (state == ST_HALT);
   assign fault    = (state == ST_FAULT);
   assign ir       = ir_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of instructions, randomized
// instruction stream against a phase-schedule model, and multi-cycle corner cases.
module tb_cpu_sequencer;

   localparam int CW_W = 38;
   localparam int TO   = 15;

   localparam int P_FETCH = 0;
   localparam int P_DEC   = 1;
   localparam int P_EXEC  = 2;
   localparam int P_MEM   = 3;
   localparam int P_WB    = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            imem_ready = 1'b0;
   logic [31:0]     imem_rdata = '0;
   logic            imem_req;
   logic [31:0]     ir;
   logic [CW_W-1:0] cw_in = '0;
   logic [CW_W-1:0] cw_out;
   logic            dmem_ready = 1'b0;
   logic            dmem_req;
   logic            dmem_we;
   logic            halt_req = 1'b0;
   logic            halted;
   logic            fault;
   logic [31:0]     retired;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_retired = '0;

   always #5 clock = ~clock;

   cpu_sequencer #(
      .CW_W       (CW_W),
      .MEM_TIMEOUT(TO)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .imem_ready(imem_ready),
      .imem_rdata(imem_rdata),
      .imem_req  (imem_req),
      .ir        (ir),
      .cw_in     (cw_in),
      .cw_out    (cw_out),
      .dmem_ready(dmem_ready),
      .dmem_req  (dmem_req),
      .dmem_we   (dmem_we),
      .halt_req  (halt_req),
      .halted    (halted),
      .fault     (fault),
      .retired   (retired)
   );

   typedef struct {
      logic [31:0] instr;
      logic [37:0] cw;
      int          fwait;
      int          mwait;
      bit          halt;
      bit          exp_halted;
   } vec_t;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Which control-word bits each phase is allowed to expose.
   function automatic logic [37:0] phase_mask(input int ph);
      logic [37:0] m;
      m = '0;
      if (ph == P_EXEC || ph == P_MEM || ph == P_WB) begin
         m[37:11] = '1;
         m[7]     = 1'b1;
         m[6]     = 1'b1;
         m[2:0]   = 3'b111;
      end
      if (ph == P_MEM) m[9:8] = 2'b11;
      if (ph == P_WB) begin
         m[10]  = 1'b1;
         m[5:3] = 3'b111;
      end
      return m;
   endfunction

   function automatic logic [37:0] make_cw(input logic [4:0] da, input logic [4:0] sa,
                                           input logic [11:0] imm, input logic [4:0] fs,
                                           input logic [10:0] lo);
      return {da, sa, imm, fs, lo};
   endfunction

   task automatic do_reset();
      reset      = 1'b1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      halt_req   = 1'b0;
      #1;
      checkOutput("rst imem_req", imem_req, 0);
      checkOutput("rst dmem_req", dmem_req, 0);
      checkOutput("rst dmem_we", dmem_we, 0);
      checkOutput("rst cw_out", cw_out, 0);
      checkOutput("rst fault", fault, 0);
      checkOutput("rst halted", halted, 0);
      step();
      checkOutput("rst ir", ir, 0);
      checkOutput("rst retired", retired, 0);
      reset = 1'b0;
      step();
      exp_retired = '0;
   endtask

   // Runs one instruction from FETCH, driving memories from a phase schedule built from the timing rules.
   task automatic applyStimulus(input logic [31:0] instr, input logic [37:0] cw,
                                input int fwait, input int mwait, input bit halt_in_exec);
      int q[$];
      int ph;
      bit last;
      for (int k = 0; k <= fwait; k++) q.push_back(P_FETCH);
      q.push_back(P_DEC);
      q.push_back(P_EXEC);
      if (cw[8]) for (int k = 0; k <= mwait; k++) q.push_back(P_MEM);
      q.push_back(P_WB);
      imem_rdata = instr;
      cw_in      = cw;
      for (int i = 0; i < q.size(); i++) begin
         ph   = q[i];
         last = (i == q.size() - 1) || (q[i+1] != ph);
         checkOutput("imem_req", imem_req, 64'(ph == P_FETCH));
         checkOutput("dmem_req", dmem_req, 64'(ph == P_MEM));
         checkOutput("dmem_we", dmem_we, 64'((ph == P_MEM) && cw[9]));
         checkOutput("cw_out", cw_out, cw & phase_mask(ph));
         checkOutput("halted", halted, 0);
         if (ph == P_DEC) begin
            checkOutput("ir", ir, instr);
            checkOutput("fault", fault, 0);
         end
         if (ph == P_WB) checkOutput("retired in wb", retired, exp_retired);
         imem_ready = (ph == P_FETCH) && last;
         dmem_ready = (ph == P_MEM) && last;
         if (ph == P_EXEC && halt_in_exec) halt_req = 1'b1;
         step();
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      exp_retired++;
      checkOutput("retired after wb", retired, exp_retired);
   endtask

   task automatic release_halt();
      for (int k = 0; k < 3; k++) begin
         step();
         checkOutput("halt held", halted, 1);
         checkOutput("halt imem_req", imem_req, 0);
         checkOutput("halt cw_out", cw_out, 0);
         checkOutput("halt retired", retired, exp_retired);
      end
      halt_req = 1'b0;
      step();
      checkOutput("resume imem_req", imem_req, 1);
      checkOutput("resume halted", halted, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t        tbl[6];
      logic [37:0] cw_alu;
      logic [37:0] cw_st;
      logic [37:0] cw_ld;
      logic [37:0] cw_br;
      logic [37:0] rcw;
      bit          rhalt;

      cw_alu = make_cw(5'd3, 5'd1, 12'h000, 5'd2, 11'h4C8);
      cw_st  = make_cw(5'd0, 5'd4, 12'h010, 5'd0, 11'h388);
      cw_ld  = make_cw(5'd7, 5'd2, 12'h024, 5'd0, 11'h508);
      cw_br  = make_cw(5'd0, 5'd0, 12'hFF0, 5'd1, 11'h033);
      tbl[0] = '{32'h1111_0001, cw_alu, 0, 0, 1'b0, 1'b0};
      tbl[1] = '{32'h2222_0002, cw_st, 0, 2, 1'b0, 1'b0};
      tbl[2] = '{32'h3333_0003, cw_ld, 2, 1, 1'b0, 1'b0};
      tbl[3] = '{32'h4444_0004, cw_br, 1, 0, 1'b0, 1'b0};
      tbl[4] = '{32'h5555_0005, cw_alu, 0, 0, 1'b1, 1'b1};
      tbl[5] = '{32'hFFFF_FFFF, '1, TO - 1, TO - 1, 1'b0, 1'b0};

      #2;
      do_reset();

      for (int i = 0; i < 6; i++) begin
         applyStimulus(tbl[i].instr, tbl[i].cw, tbl[i].fwait, tbl[i].mwait, tbl[i].halt);
         checkOutput("end halted", halted, 64'(tbl[i].exp_halted));
         checkOutput("end imem_req", imem_req, 64'(!tbl[i].exp_halted));
         if (tbl[i].exp_halted) release_halt();
      end

      for (int i = 0; i < 30; i++) begin
         rcw   = 38'({$urandom(), $urandom()});
         rhalt = ($urandom_range(0, 7) == 0);
         applyStimulus($urandom(), rcw, $urandom_range(0, 5), $urandom_range(0, 5), rhalt);
         checkOutput("rnd halted", halted, 64'(rhalt));
         if (rhalt) release_halt();
      end

      // Counter wrap: preload the retired register, then retire one more.
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      exp_retired = 32'hFFFF_FFFF;
      applyStimulus(32'h0BAD_0001, cw_alu, 0, 0, 1'b0);
      checkOutput("retired wrap", retired, 0);

      // Instruction memory never answers: fault after exactly TO fetch cycles.
      imem_ready = 1'b0;
      for (int k = 0; k < TO; k++) begin
         checkOutput("to imem_req", imem_req, 1);
         checkOutput("to fault", fault, 0);
         step();
      end
      checkOutput("fault set", fault, 1);
      checkOutput("fault imem_req", imem_req, 0);
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
      checkOutput("fault sticky", fault, 1);
      checkOutput("fault cw_out", cw_out, 0);
      checkOutput("fault dmem_req", dmem_req, 0);
      checkOutput("fault retired", retired, exp_retired);
      checkOutput("fault ir", ir, 32'h0BAD_0001);
      do_reset();

      // Reset during a MEM write cycle must drop every strobe immediately.
      imem_rdata = 32'h7777_0007;
      cw_in      = cw_st;
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      step();
      step();
      checkOutput("mem dmem_req", dmem_req, 1);
      checkOutput("mem dmem_we", dmem_we, 1);
      checkOutput("mem cw_out", cw_out, cw_st & phase_mask(P_MEM));
      #2;
      do_reset();
      checkOutput("restart imem_req", imem_req, 1);
      applyStimulus(32'h8888_0008, cw_alu, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
